// File: rtl/neuron_out_serializer_pkg.sv
// Shared types and helpers for the neuron output serializer.
// Holds the stream state encoding, default frame geometry and word slicing.
package serializer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int DWIDTH_DEF = 32;
  localparam int NUM_DEF    = 10;

  // LSB position of word k inside a flat bus of w-bit words.
  function automatic int word_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/neuron_out_serializer_if.sv
// Valid/ready word stream leaving the serializer: data, index and last marker.
interface neuron_out_serializer_if
  import serializer_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int IDXW   = $clog2(NUM_DEF)
) ();

  logic signed [DWIDTH-1:0] out_data;
  logic [IDXW-1:0]          out_idx;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output out_data, out_idx, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/neuron_out_serializer_shadow_bank.sv
// Bank of NUM enabled word registers that snapshot a whole frame in one cycle.
module ser_shadow_bank
  import serializer_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NUM    = NUM_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [NUM*DWIDTH-1:0] i_bus,
  output logic [NUM*DWIDTH-1:0] o_bank
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_word
      logic [DWIDTH-1:0] r_word;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_word <= '0;
        end else if (i_we) begin
          r_word <= i_bus[word_lo(gi, DWIDTH) +: DWIDTH];
        end
      end

      assign o_bank[gi*DWIDTH +: DWIDTH] = r_word;
    end
  endgenerate

endmodule

// File: rtl/neuron_out_serializer.sv
// Snapshots a parallel bank of neuron outputs on load and streams it one word
// per valid/ready transfer, pulsing done after the last word is accepted.
module neuron_out_serializer
  import serializer_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int NUM    = NUM_DEF,
  parameter int IDXW   = $clog2(NUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM*DWIDTH-1:0]   in_bus,
  output logic                    busy,
  output logic                    done,
  neuron_out_serializer_if.master m_out
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [IDXW-1:0]       r_idx;
  logic [IDXW-1:0]       w_idx_next;
  logic                  r_done;
  logic                  w_done_next;
  logic                  w_load_en;
  logic                  w_fire;
  logic [NUM*DWIDTH-1:0] w_bank;

  ser_shadow_bank #(
    .DWIDTH(DWIDTH),
    .NUM   (NUM)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .i_we  (w_load_en),
    .i_bus (in_bus),
    .o_bank(w_bank)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    w_load_en    = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      IDLE: begin
        // A load while streaming never reaches the bank: enable exists only here.
        if (load) begin
          w_load_en    = 1'b1;
          w_idx_next   = '0;
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        w_fire = m_out.out_ready;
        if (w_fire) begin
          if (r_idx == LAST_IDX) begin
            w_idx_next   = '0;
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decode registered state only, so out_ready never reaches out_valid.
  assign busy            = (r_state == STREAM);
  assign done            = r_done;
  assign m_out.out_valid = busy;
  assign m_out.out_idx   = r_idx;
  assign m_out.out_last  = busy && (r_idx == LAST_IDX);
  assign m_out.out_data  = busy ? $signed(w_bank[word_lo(int'(r_idx), DWIDTH) +: DWIDTH])
                                : '0;

endmodule

// File: tb/tb_neuron_out_serializer.sv
// Directed bench for neuron_out_serializer: frames, backpressure, overwrite,
// back-to-back loads, mid-frame reset and idle behaviour.
module tb_neuron_out_serializer;
  import serializer_pkg::*;

  localparam int DW = 32;
  localparam int N  = 10;
  localparam int IW = $clog2(N);

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          load   = 1'b0;
  logic [N*DW-1:0] in_bus = '0;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [N*DW-1:0] f_a, f_b, f_c, f_d;

  neuron_out_serializer_if #(.DWIDTH(DW), .IDXW(IW)) out_if ();

  neuron_out_serializer #(
    .DWIDTH(DW),
    .NUM   (N),
    .IDXW  (IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .in_bus(in_bus),
    .busy  (busy),
    .done  (done),
    .m_out (out_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] make_frame(input int base, input int step);
    logic [N*DW-1:0] f;
    for (int k = 0; k < N; k++) f[k*DW +: DW] = 32'(base + k * step);
    return f;
  endfunction

  function automatic logic [DW-1:0] word(input logic [N*DW-1:0] f, input int k);
    return f[k*DW +: DW];
  endfunction

  // Called at a negedge with load already driven for one edge; ends at the done cycle.
  task automatic stream_frame(input string tag, input logic [N*DW-1:0] f,
                              input int load_at, input bit overwrite);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      load = (k == load_at);
      if (overwrite && k == 0) in_bus = {N{32'h7FFF_FFFF}};
      out_if.out_ready = 1'b1;
      check({tag, "_valid"}, out_if.out_valid, 1);
      check({tag, "_data"}, $unsigned(out_if.out_data), word(f, k));
      check({tag, "_idx"}, out_if.out_idx, k);
      check({tag, "_last"}, out_if.out_last, (k == N - 1));
      check({tag, "_nodone"}, done, 0);
      $display("%s word idx=%0d data=%0d", tag, out_if.out_idx, out_if.out_data);
    end
    @(negedge clk);
    load = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_end_valid"}, out_if.out_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e, cyc, stall;
    bit rdy;
    out_if.out_ready = 1'b0;

    #1 reset = 1'b0;
    #2;
    check("rst_valid", out_if.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", $unsigned(out_if.out_data), 0);
    check("rst_idx", out_if.out_idx, 0);
    check("rst_last", out_if.out_last, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic frame: -500, -400, ... 400.
    @(negedge clk);
    f_a = make_frame(-500, 100);
    in_bus = f_a;
    load = 1'b1;
    stream_frame("basic", f_a, -1, 1'b0);
    @(negedge clk);
    check("basic_done_clear", done, 0);
    check("basic_idle_valid", out_if.out_valid, 0);

    // Backpressure: alternate ready, plus a 5-cycle stall on word 3.
    f_b = make_frame(-123457, 98765);
    in_bus = f_b;
    load = 1'b1;
    e = 0; cyc = 0; stall = 0;
    while (e < N && cyc < 80) begin
      @(negedge clk);
      load = 1'b0;
      check("bp_valid", out_if.out_valid, 1);
      check("bp_data", $unsigned(out_if.out_data), word(f_b, e));
      check("bp_idx", out_if.out_idx, e);
      if (e == 3 && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = cyc[0];
      end
      out_if.out_ready = rdy;
      @(posedge clk);
      if (rdy) begin
        $display("bp word idx=%0d data=%0d", out_if.out_idx, out_if.out_data);
        e++;
      end
      cyc++;
    end
    check("bp_handshakes", e, N);
    check("bp_stall_cycles", stall, 5);
    @(negedge clk);
    check("bp_done", done, 1);
    check("bp_end_valid", out_if.out_valid, 0);

    // Source overwrite after capture and an ignored load at idx 4.
    @(negedge clk);
    f_c = make_frame(1000, -333);
    in_bus = f_c;
    load = 1'b1;
    stream_frame("ovw", f_c, 4, 1'b1);
    @(negedge clk);
    check("ovw_no_restart", out_if.out_valid, 0);
    check("ovw_done_clear", done, 0);

    // Back-to-back: frame B loaded during the done cycle of frame A.
    in_bus = f_a;
    load = 1'b1;
    stream_frame("b2bA", f_a, -1, 1'b0);
    f_d = {N{32'h8000_0000}};
    in_bus = f_d;
    load = 1'b1;
    stream_frame("b2bB", f_d, -1, 1'b0);

    // Asynchronous reset while word 6 is presented.
    @(negedge clk);
    in_bus = f_b;
    load = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      load = 1'b0;
      out_if.out_ready = 1'b1;
      check("rstmid_idx", out_if.out_idx, k);
    end
    #2 reset = 1'b0;
    #1;
    check("rstmid_valid", out_if.out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_data", $unsigned(out_if.out_data), 0);
    check("rstmid_idx0", out_if.out_idx, 0);
    check("rstmid_last", out_if.out_last, 0);
    repeat (2) begin
      @(negedge clk);
      check("rstmid_hold_done", done, 0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_post_valid", out_if.out_valid, 0);
      check("rstmid_post_done", done, 0);
    end
    in_bus = f_a;
    load = 1'b1;
    stream_frame("rstnew", f_a, -1, 1'b0);

    // Idle hygiene: no load, inputs wiggle.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_flags", {out_if.out_valid, busy, done}, 3'b000);
      out_if.out_ready = 1'($urandom);
      for (int k = 0; k < N; k++) in_bus[k*DW +: DW] = $urandom;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
